// File: rtl/xfer_rate_sched_pkg.sv
// xfer_rate_sched_pkg: shared state encoding and reset-time divisor defaults
package xfer_rate_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam int DIV_W_DEF  = 4;
    localparam int WR_DIV_DEF = 2;
    localparam int RD_DIV_DEF = 3;

endpackage

// File: rtl/xfer_rate_sched_strobe.sv
// rate_strobe: phase counter 0..div-1 that flags when the next cycle is a slot
module rate_strobe
    import xfer_rate_sched_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_slot_nx
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nx;
    logic [DIV_W-1:0] w_last;

    // Next phase is zero while cleared, otherwise wraps after div-1; the slot flag looks one cycle ahead
    always_comb begin
        w_last    = i_div - DIV_W'(1);
        w_cnt_nx  = (i_clear || r_cnt >= w_last) ? '0 : r_cnt + DIV_W'(1);
        o_slot_nx = w_cnt_nx == w_last;
    end

    // Phase register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_cnt <= '0;
        else            r_cnt <= w_cnt_nx;
    end

endmodule

// File: rtl/xfer_rate_sched.sv
// xfer_rate_sched: run/stop FSM and divided write/read strobe generator for the FIFO ports
module xfer_rate_sched
    import xfer_rate_sched_pkg::*;
#(
    parameter int DIV_W      = DIV_W_DEF,
    parameter int WR_DIV_RST = WR_DIV_DEF,
    parameter int RD_DIV_RST = RD_DIV_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [DIV_W-1:0] i_cfg_wr_div,
    input  logic [DIV_W-1:0] i_cfg_rd_div,
    output logic             o_cfg_err,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_fifo_full,
    input  logic             i_fifo_empty,
    output logic             o_wr_en,
    output logic             o_rd_en,
    output logic             o_wr_drop,
    output logic             o_rd_drop,
    output logic             o_busy
);

    state_t           r_state;
    state_t           w_nstate;
    logic [DIV_W-1:0] r_wr_div;
    logic [DIV_W-1:0] r_rd_div;
    logic [DIV_W-1:0] w_wr_div_nx;
    logic [DIV_W-1:0] w_rd_div_nx;
    logic             w_idle;
    logic             w_cfg_bad;
    logic             w_cfg_load;
    logic             w_wr_slot;
    logic             w_rd_slot;
    logic             w_wr_live;
    logic             w_rd_live;
    logic             r_cfg_err;
    logic             r_wr_en;
    logic             r_rd_en;
    logic             r_wr_drop;
    logic             r_rd_drop;

    // Config acceptance and next-state; strobes are decided against the state they will appear in
    always_comb begin
        w_idle      = r_state == ST_IDLE;
        w_cfg_bad   = i_cfg_wr_div == '0 || i_cfg_rd_div == '0;
        w_cfg_load  = w_idle && i_cfg_valid && !w_cfg_bad;
        w_wr_div_nx = w_cfg_load ? i_cfg_wr_div : r_wr_div;
        w_rd_div_nx = w_cfg_load ? i_cfg_rd_div : r_rd_div;
        w_nstate    = r_state;
        case (r_state)
            ST_IDLE:  if (i_start && !i_stop) w_nstate = ST_RUN;
            ST_RUN:   if (i_stop) w_nstate = i_fifo_empty ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (i_fifo_empty) w_nstate = ST_IDLE;
            default:  w_nstate = ST_IDLE;
        endcase
        w_wr_live   = w_nstate == ST_RUN && w_wr_slot;
        w_rd_live   = w_nstate != ST_IDLE && w_rd_slot;
    end

    rate_strobe #(.DIV_W(DIV_W)) u_wr (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (w_idle),
        .i_div     (w_wr_div_nx),
        .o_slot_nx (w_wr_slot)
    );

    rate_strobe #(.DIV_W(DIV_W)) u_rd (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (w_idle),
        .i_div     (w_rd_div_nx),
        .o_slot_nx (w_rd_slot)
    );

    // State, divisors and registered strobes/pulses
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_wr_div  <= DIV_W'(WR_DIV_RST);
            r_rd_div  <= DIV_W'(RD_DIV_RST);
            r_cfg_err <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_wr_drop <= 1'b0;
            r_rd_drop <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_wr_div  <= w_wr_div_nx;
            r_rd_div  <= w_rd_div_nx;
            r_cfg_err <= w_idle && i_cfg_valid && w_cfg_bad;
            r_wr_en   <= w_wr_live && !i_fifo_full;
            r_wr_drop <= w_wr_live && i_fifo_full;
            r_rd_en   <= w_rd_live && !i_fifo_empty;
            r_rd_drop <= w_rd_live && i_fifo_empty;
        end
    end

    assign o_cfg_ready = w_idle;
    assign o_busy      = !w_idle;
    assign o_cfg_err   = r_cfg_err;
    assign o_wr_en     = r_wr_en;
    assign o_rd_en     = r_rd_en;
    assign o_wr_drop   = r_wr_drop;
    assign o_rd_drop   = r_rd_drop;

endmodule

// File: tb/tb_xfer_rate_sched.sv
// tb_xfer_rate_sched: scoreboard bench against a slot-arithmetic reference model
module tb_xfer_rate_sched;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       cfg_valid  = 1'b0;
    logic [3:0] cfg_wr_div = 4'd0;
    logic [3:0] cfg_rd_div = 4'd0;
    logic       start      = 1'b0;
    logic       stop       = 1'b0;
    logic       fifo_full  = 1'b0;
    logic       fifo_empty = 1'b0;
    logic       cfg_ready, cfg_err, wr_en, rd_en, wr_drop, rd_drop, busy;

    typedef struct {
        int         c;
        logic [6:0] v;
    } exp_t;

    localparam logic [6:0] RST_V = 7'b1000000;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_mode = 0;
    int   m_wd   = 2;
    int   m_rd   = 3;
    int   m_k    = 0;

    xfer_rate_sched dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_wr_div (cfg_wr_div),
        .i_cfg_rd_div (cfg_rd_div),
        .o_cfg_err    (cfg_err),
        .i_start      (start),
        .i_stop       (stop),
        .i_fifo_full  (fifo_full),
        .i_fifo_empty (fifo_empty),
        .o_wr_en      (wr_en),
        .o_rd_en      (rd_en),
        .o_wr_drop    (wr_drop),
        .o_rd_drop    (rd_drop),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_step();
        int         nm;
        logic       err, ws, rs;
        nm  = m_mode;
        err = m_mode == 0 && cfg_valid && (cfg_wr_div == 0 || cfg_rd_div == 0);
        if (m_mode == 0 && cfg_valid && !err) begin
            m_wd = int'(cfg_wr_div);
            m_rd = int'(cfg_rd_div);
        end
        if (m_mode == 0 && start && !stop) begin
            nm  = 1;
            m_k = cyc;
        end else if (m_mode == 1 && stop) begin
            nm = fifo_empty ? 0 : 2;
        end else if (m_mode == 2 && fifo_empty) begin
            nm = 0;
        end
        ws = nm == 1 && ((cyc + 1 - m_k) % m_wd) == 0;
        rs = nm != 0 && ((cyc + 1 - m_k) % m_rd) == 0;
        q.push_back('{c: cyc + 1, v: {nm == 0, err, ws && !fifo_full, rs && !fifo_empty,
                                      ws && fifo_full, rs && fifo_empty, nm != 0}});
        m_mode = nm;
    endtask

    task automatic hold_reset();
        q.push_back('{c: cyc, v: RST_V});
        q.push_back('{c: cyc + 1, v: RST_V});
        m_mode = 0;
        m_wd   = 2;
        m_rd   = 3;
        m_k    = 0;
    endtask

    task automatic drive(input logic v, input int wd, input int rd, input logic st,
                         input logic sp, input logic f, input logic e);
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        cfg_valid  = v;
        cfg_wr_div = 4'(wd);
        cfg_rd_div = 4'(rd);
        start      = st;
        stop       = sp;
        fifo_full  = f;
        fifo_empty = e;
        model_step();
    endtask

    task automatic idle_n(input int n, input logic f, input logic e);
        repeat (n) drive(1'b0, 0, 0, 1'b0, 1'b0, f, e);
    endtask

    initial forever begin
        exp_t       e;
        logic [6:0] act;
        @(negedge clk or negedge reset_n);
        #1;
        while (q.size() > 0 && q[0].c < cyc) begin
            e = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL stale: expectation for cycle %0d not compared (now %0d)", e.c, cyc);
        end
        if (q.size() > 0 && q[0].c == cyc) begin
            e   = q.pop_front();
            act = {cfg_ready, cfg_err, wr_en, rd_en, wr_drop, rd_drop, busy};
            n_chk++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d {cfg_ready,cfg_err,wr_en,rd_en,wr_drop,rd_drop,busy} got %b expected %b",
                         cyc, act, e.v);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        hold_reset();
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(12, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_n(5, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_n(2, 1'b0, 1'b1);
        drive(1'b1, 1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(12, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 0, 7, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(10, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 2, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(3, 1'b0, 1'b0);
        idle_n(6, 1'b1, 1'b0);
        idle_n(4, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_n(2, 1'b0, 1'b0);
        drive(1'b1, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(5, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_n(3, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        q.delete();
        hold_reset();
        #1;
        n_chk++;
        if ({cfg_ready, cfg_err, wr_en, rd_en, wr_drop, rd_drop, busy} !== RST_V) begin
            n_fail++;
            $display("FAIL async reset: outputs %b expected %b",
                     {cfg_ready, cfg_err, wr_en, rd_en, wr_drop, rd_drop, busy}, RST_V);
        end
        drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(10, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %0d expectations never compared", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
